// File: rtl/acq_ctrl.sv
// acq_ctrl: arm/trigger acquisition controller. Captures DEPTH samples into a
// local buffer after a trigger, then streams them out over a valid/ready port.
module acq_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_en_c;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  // Next-state, pointer and registered-output computation; abort overrides all.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en_c  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (trig) begin
          state_d = CAPTURE;
          if (smp_valid) begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (smp_valid) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + CNT_W'(1);
          if (wr_ptr_q == LAST_IDX) state_d = READOUT;
        end
      end
      READOUT: begin
        if (rd_valid_q && rd_ready) begin
          rd_ptr_d = rd_ptr_q + CNT_W'(1);
          if (rd_last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wr_en_c  = 1'b0;
      done_d   = 1'b0;
    end

    rd_valid_d = (state_d == READOUT);
    rd_last_d  = rd_valid_d && (rd_ptr_d == LAST_IDX);
    rd_data_d  = rd_valid_d ? mem_q[rd_ptr_d] : '0;
    busy_d     = (state_d != IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Sample buffer; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= smp_data;
  end

  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_acq_ctrl.sv
// Directed bench for acq_ctrl with DEPTH=4, DATA_W=8.
module tb_acq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       trig = 1'b0;
  logic       smp_valid = 1'b0;
  logic [7:0] smp_data = 8'h00;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  acq_ctrl #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
    .smp_valid(smp_valid), .smp_data(smp_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: arm, trigger with first sample, then three more samples.
  task automatic capture4(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; smp_valid = 1'b1; smp_data = d0; tick(); trig = 1'b0;
    smp_data = d1; tick();
    smp_data = d2; tick();
    smp_data = d3; tick();
    smp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({rd_valid, rd_last, busy, done} !== 4'b0000 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b b=%b d=%b data=%h want all 0",
               rd_valid, rd_last, busy, done, rd_data);
    end
    arm = 1'b1; tick(); arm = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_arm_busy got %b want 1", busy); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_abort_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] exp [4];
    exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
    capture4(b0, b1, b2, b3);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i] || rd_last !== (i == 3)) begin
        errors++;
        $display("FAIL basic_read%0d got v=%b data=%h last=%b want 1 %h %b",
                 i, rd_valid, rd_data, rd_last, exp[i], (i == 3));
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b v=%b want 1 0 0", done, busy, rd_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4];
    logic       pat [4];
    int         idx;
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3; exp[3] = 8'hA4;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    smp_valid = 1'b1; smp_data = exp[0]; tick();
    smp_valid = 1'b0; tick();
    smp_valid = 1'b1; smp_data = exp[1]; tick();
    smp_valid = 1'b0; tick(); tick();
    smp_valid = 1'b1; smp_data = exp[2]; tick();
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL gap_still_capture got v=%b busy=%b want 0 1", rd_valid, busy);
    end
    smp_data = exp[3]; tick();
    smp_valid = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      rd_ready = pat[cyc % 4];
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp[idx] || rd_last !== (idx == 3)) begin
        errors++;
        $display("FAIL bp_cyc%0d got v=%b data=%h last=%b want 1 %h %b",
                 cyc, rd_valid, rd_data, rd_last, exp[idx], (idx == 3));
      end
      tick();
      if (pat[cyc % 4]) idx++;
    end
    rd_ready = 1'b0;
    checks++;
    if (idx !== 4 || done !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end got xfers=%0d done=%b v=%b want 4 1 0", idx, done, rd_valid);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] exp [4];
    exp[0] = 8'h51; exp[1] = 8'h52; exp[2] = 8'h53; exp[3] = 8'h54;
    trig = 1'b1; smp_valid = 1'b1; smp_data = 8'hEE; tick();
    trig = 1'b0; smp_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL trig_idle got busy=%b want 0", busy); end
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; smp_valid = 1'b1; smp_data = exp[0]; tick(); trig = 1'b0;
    arm = 1'b1; trig = 1'b1; smp_data = exp[1]; tick(); arm = 1'b0; trig = 1'b0;
    smp_data = exp[2]; tick();
    smp_data = exp[3]; tick();
    smp_data = 8'hEE;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i] || rd_last !== (i == 3)) begin
        errors++;
        $display("FAIL ign_read%0d got v=%b data=%h last=%b want 1 %h %b",
                 i, rd_valid, rd_data, rd_last, exp[i], (i == 3));
      end
      smp_data = 8'hE0 + 8'(i);
      tick();
    end
    smp_valid = 1'b0; rd_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_done got done=%b busy=%b want 1 0", done, busy);
    end
    tick();
  endtask

  task automatic test_abort();
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL arm_abort_idle got busy=%b want 0", busy); end
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; smp_valid = 1'b1; smp_data = 8'h61; tick(); trig = 1'b0;
    smp_data = 8'h62; tick();
    abort = 1'b1; smp_data = 8'h63; tick(); abort = 1'b0; smp_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b v=%b done=%b want 0 0 0", busy, rd_valid, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done got done=%b busy=%b want 0 0", done, busy);
    end
    test_basic(8'h71, 8'h72, 8'h73, 8'h74);
  endtask

  task automatic test_midrun_reset();
    capture4(8'h81, 8'h82, 8'h83, 8'h84);
    rd_ready = 1'b1;
    tick(); tick();
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h83) begin
      errors++; $display("FAIL mid_pre got v=%b data=%h want 1 83", rd_valid, rd_data);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got v=%b busy=%b last=%b data=%h want 0 0 0 00",
               rd_valid, busy, rd_last, rd_data);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_stay_idle got busy=%b v=%b want 0 0", busy, rd_valid);
    end
    test_basic(8'h91, 8'h92, 8'h93, 8'h94);
  endtask

  initial begin
    test_reset();
    test_basic(8'h11, 8'h22, 8'h33, 8'h44);
    test_backpressure();
    test_ignored();
    test_abort();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
